rx_chain_sequencer: RTL

Control and strobe scheduler for one receive DDC chain (NCO/CORDIC -> CIC decimator -> halfband decimator).
- Owns the chain's serial-programmed run and decimation-rate registers.
- Generates the chain's sample_strobe and decimator_strobe, and sequences enable/reset so rate changes never corrupt CIC state.
- Sits between the serial control bus, the ADC sample strobe and the chain instance; counts output (halfband) samples for status.

---
 rtl/rx_seq_pkg.sv | 24 ++
 rtl/rx_strobe_div.sv | 37 +++
 rtl/rx_chain_sequencer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/rx_seq_pkg.sv
// Shared definitions for the receive-chain sequencer and its strobe divider.
//   - rx_state_e    : sequencer state encoding
//   - RATEADDR_DEF  : default serial address of the decimation-rate register
//   - CTRLADDR_DEF  : default serial address of the control register
//   - RATE_RST      : rate register / applied rate after reset
//   - rate_reload() : counter reload value for a rate (rate 0 behaves as 1)
package rx_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_RUN   = 2'd2
  } rx_state_e;

  localparam logic [6:0] RATEADDR_DEF = 7'd8;
  localparam logic [6:0] CTRLADDR_DEF = 7'd9;
  localparam logic [7:0] RATE_RST     = 8'd1;

  // Rate 0 would otherwise underflow to 255; treat it as divide-by-1.
  function automatic logic [7:0] rate_reload(input logic [7:0] rate);
    return (rate == 8'd0) ? 8'd0 : rate - 8'd1;
  endfunction

endpackage

// File: rtl/rx_strobe_div.sv
// Strobe divider: emits one strobe_out per 'rate' strobe_in pulses.
// Ports:
//   clock, reset  : clock, async active-high reset
//   load          : (re)arm the divider with 'rate'; wins over counting
//   rate[7:0]     : division ratio, captured on load (0 behaves as 1)
//   strobe_in     : input strobe
//   strobe_out    : combinational, coincident with the strobe_in it marks
module rx_strobe_div
  import rx_seq_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] rate,
  input  logic       strobe_in,
  output logic       strobe_out
);

  logic [7:0] r_reload;
  logic [7:0] r_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_reload <= 8'd0;
      r_cnt    <= 8'd0;
    end else if (load) begin
      r_reload <= rate_reload(rate);
      r_cnt    <= rate_reload(rate);
    end else if (strobe_in) begin
      // Reload at zero instead of decrementing, so the count never wraps.
      r_cnt <= (r_cnt == 8'd0) ? r_reload : r_cnt - 8'd1;
    end
  end

  assign strobe_out = strobe_in & (r_cnt == 8'd0);

endmodule

// File: rtl/rx_chain_sequencer.sv
// Control and strobe scheduler for one receive DDC chain
// (NCO/CORDIC -> CIC decimator -> halfband decimator).
// Ports:
//   clock, reset        : system clock, async active-high reset
//   serial_addr/data/strobe : serial register write bus
//   adc_strobe          : raw input-sample valid
//   hb_strobe           : output-sample strobe returned from the chain
//   chain_enable/reset  : chain enable and synchronous reset
//   decim_rate          : CIC rate applied to the chain (changes only in FLUSH)
//   sample_strobe       : gated input-sample strobe to the chain
//   decimator_strobe    : CIC output strobe to the chain
//   busy                : run requested but chain not yet running
//   out_count           : hb_strobe count since last RUN entry
module rx_chain_sequencer
  import rx_seq_pkg::*;
#(
  parameter logic [6:0]  RATEADDR     = RATEADDR_DEF,
  parameter logic [6:0]  CTRLADDR     = CTRLADDR_DEF,
  parameter int unsigned FLUSH_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [6:0]  serial_addr,
  input  logic [31:0] serial_data,
  input  logic        serial_strobe,
  input  logic        adc_strobe,
  input  logic        hb_strobe,
  output logic        chain_enable,
  output logic        chain_reset,
  output logic [7:0]  decim_rate,
  output logic        sample_strobe,
  output logic        decimator_strobe,
  output logic        busy,
  output logic [15:0] out_count
);

  localparam logic [7:0] FLUSH_LOAD = 8'(FLUSH_CYCLES - 1);

  rx_state_e   r_state;
  rx_state_e   w_state_nxt;
  logic        r_run;
  logic [7:0]  r_rate;
  logic [7:0]  r_flush_cnt;
  logic [7:0]  r_decim_rate;
  logic        r_chain_enable;
  logic        r_chain_reset;
  logic        r_sample_strobe;
  logic [15:0] r_out_count;

  logic        w_rate_wr;
  logic        w_ctrl_wr;
  logic        w_run_nxt;
  logic [7:0]  w_rate_nxt;
  logic        w_flush_load;
  logic        w_run_entry;
  logic        w_stay_run;
  logic        w_dec_strobe;
  logic        w_unused_data;

  assign w_rate_wr = serial_strobe & (serial_addr == RATEADDR);
  assign w_ctrl_wr = serial_strobe & (serial_addr == CTRLADDR);

  // Write-through views so a write and the transition it causes share an
  // edge; the rate applied on FLUSH entry is the one just written.
  assign w_run_nxt  = w_ctrl_wr ? serial_data[0]   : r_run;
  assign w_rate_nxt = w_rate_wr ? serial_data[7:0] : r_rate;

  // Upper data bits belong to neither register.
  assign w_unused_data = ^serial_data[31:8];

  always_comb begin
    w_state_nxt  = r_state;
    w_flush_load = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_run_nxt) begin
          w_state_nxt  = ST_FLUSH;
          w_flush_load = 1'b1;
        end
      end
      ST_FLUSH: begin
        if (w_rate_wr) begin
          // New rate mid-flush: start the flush over and reapply the rate.
          w_flush_load = 1'b1;
        end else if (r_flush_cnt == 8'd0) begin
          w_state_nxt = w_run_nxt ? ST_RUN : ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_ctrl_wr && !serial_data[0]) begin
          w_state_nxt = ST_IDLE;
        end else if (w_rate_wr) begin
          w_state_nxt  = ST_FLUSH;
          w_flush_load = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_run_entry = (r_state != ST_RUN) && (w_state_nxt == ST_RUN);
  assign w_stay_run  = (r_state == ST_RUN) && (w_state_nxt == ST_RUN);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_run           <= 1'b0;
      r_rate          <= RATE_RST;
      r_flush_cnt     <= 8'd0;
      r_decim_rate    <= RATE_RST;
      r_chain_enable  <= 1'b0;
      r_chain_reset   <= 1'b1;
      r_sample_strobe <= 1'b0;
      r_out_count     <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_run   <= w_run_nxt;
      r_rate  <= w_rate_nxt;

      if (w_flush_load) begin
        r_flush_cnt  <= FLUSH_LOAD;
        r_decim_rate <= w_rate_nxt;
      end else if (r_state == ST_FLUSH && r_flush_cnt != 8'd0) begin
        r_flush_cnt <= r_flush_cnt - 8'd1;
      end

      // Outputs registered from next state so they track r_state exactly.
      r_chain_enable <= (w_state_nxt == ST_RUN);
      r_chain_reset  <= (w_state_nxt != ST_RUN);

      // No sample goes out on the edge that leaves RUN.
      r_sample_strobe <= adc_strobe & w_stay_run;

      if (w_run_entry) begin
        r_out_count <= 16'd0;
      end else if (r_state == ST_RUN && hb_strobe) begin
        r_out_count <= r_out_count + 16'd1;
      end
    end
  end

  // The divider is armed on FLUSH entry with the same rate the chain gets.
  rx_strobe_div u_div (
    .clock     (clock),
    .reset     (reset),
    .load      (w_flush_load),
    .rate      (w_rate_nxt),
    .strobe_in (r_sample_strobe),
    .strobe_out(w_dec_strobe)
  );

  assign chain_enable     = r_chain_enable;
  assign chain_reset      = r_chain_reset;
  assign decim_rate       = r_decim_rate;
  assign sample_strobe    = r_sample_strobe;
  assign decimator_strobe = w_dec_strobe;
  assign busy             = r_run & (r_state != ST_RUN);
  assign out_count        = r_out_count;

endmodule
